// File: rtl/vram_arb.sv
// rtl/vram_arb.sv - VRAM arbiter: video / CPU / fill requesters onto one synchronous RAM port
//
// Purpose:
//   Chooses one winner at each rising edge and registers its address, write data
//   and write enable onto the RAM port. Video has priority. CPU and fill share the
//   remaining slots round-robin. A two-stage owner pipeline returns each read
//   (vid_valid / cpu_ack) and each write ack two edges after the grant.
//   Optional macro VRAM_ARB_STARVE_EN adds a saturating starvation counter that
//   forces a CPU slot after STARVE_LIMIT consecutive video wins and flags the lost
//   video slot on vid_stall.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   vid_req/vid_addr                fire-and-forget video fetch
//   vid_valid/vid_rdata/vid_stall   video response, lost-slot flag
//   cpu_req/cpu_we/cpu_addr/cpu_wdata, cpu_ack/cpu_rdata   CPU access
//   fill_req/fill_addr/fill_wdata, fill_ack                fill/clear writes
//   mem_addr/mem_wdata/mem_we, mem_rdata                   RAM port
module vram_arb #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_wdata,
  output logic              fill_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              vid_stall
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_FILL = 2'd3
  } owner_e;

  owner_e              s1_q, s1_d, s2_q, s2_d, grant;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic                last_rr_q, last_rr_d;   // 0 = CPU granted last, 1 = fill
  logic                cpu_elig, fill_elig, force_cpu;

  // A requester stays ineligible while its grant sits in either pipeline stage,
  // which covers edges E1 and E2 where its req is still high.
  assign cpu_elig  = cpu_req  && (s1_q != OWN_CPU)  && (s2_q != OWN_CPU);
  assign fill_elig = fill_req && (s1_q != OWN_FILL) && (s2_q != OWN_FILL);

`ifdef VRAM_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;
  logic          stall1_q, stall1_d, stall2_q, stall2_d;

  assign force_cpu = cpu_elig && (starve_q == LIMIT);

  always_comb begin
    starve_d = starve_q;
    if (!cpu_req || grant == OWN_CPU)
      starve_d = '0;
    else if (grant == OWN_VID && cpu_elig && starve_q != LIMIT)
      starve_d = starve_q + CW'(1);
    // Stall rides the pipeline so it lines up with the vid_valid it replaces.
    stall1_d = force_cpu && vid_req;
    stall2_d = stall1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
      stall1_q <= 1'b0;
      stall2_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall1_q <= stall1_d;
      stall2_q <= stall2_d;
    end
  end

  assign vid_stall = stall2_q;
`else
  assign force_cpu = 1'b0;
  assign vid_stall = 1'b0;
`endif

  always_comb begin
    grant       = OWN_NONE;
    last_rr_d   = last_rr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;

    if (force_cpu)
      grant = OWN_CPU;
    else if (vid_req)
      grant = OWN_VID;
    else if (cpu_elig && fill_elig)
      grant = last_rr_q ? OWN_CPU : OWN_FILL;
    else if (cpu_elig)
      grant = OWN_CPU;
    else if (fill_elig)
      grant = OWN_FILL;

    case (grant)
      OWN_VID: begin
        mem_addr_d = vid_addr;
      end
      OWN_CPU: begin
        mem_addr_d  = cpu_addr;
        mem_wdata_d = cpu_wdata;
        mem_we_d    = cpu_we;
        last_rr_d   = 1'b0;
      end
      OWN_FILL: begin
        mem_addr_d  = fill_addr;
        mem_wdata_d = fill_wdata;
        mem_we_d    = 1'b1;
        last_rr_d   = 1'b1;
      end
      default: ;
    endcase

    s1_d = grant;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q        <= OWN_NONE;
      s2_q        <= OWN_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      last_rr_q   <= 1'b1;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      last_rr_q   <= last_rr_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

  // Stage 2 owner coincides with the RAM returning data for that slot.
  assign vid_valid = (s2_q == OWN_VID);
  assign cpu_ack   = (s2_q == OWN_CPU);
  assign fill_ack  = (s2_q == OWN_FILL);
  assign vid_rdata = mem_rdata;
  assign cpu_rdata = mem_rdata;

endmodule

// File: tb/tb_vram_arb.sv
// tb/tb_vram_arb.sv - directed self-checking bench for vram_arb
module tb_vram_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vid_req = 1'b0;
  logic [13:0] vid_addr = '0;
  logic        vid_valid;
  logic [7:0]  vid_rdata;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [13:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        fill_req = 1'b0;
  logic [13:0] fill_addr = '0;
  logic [7:0]  fill_wdata = '0;
  logic        fill_ack;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata = '0;
  logic        vid_stall;

  logic [7:0]  ram [0:16383];
  logic        pl_we = 1'b0;
  logic [13:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  int total = 0;
  int bad = 0;

  vram_arb #(.ADDR_W(14), .DATA_W(8), .STARVE_LIMIT(15)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .fill_req(fill_req), .fill_addr(fill_addr), .fill_wdata(fill_wdata), .fill_ack(fill_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .vid_stall(vid_stall)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model with a bench-side preload port.
  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [13:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_we = 1'b1;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if ({vid_valid, cpu_ack, fill_ack, mem_we, vid_stall} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 00000", {vid_valid, cpu_ack, fill_ack, mem_we, vid_stall});
    end
    total++;
    if (mem_addr !== 14'h0 || mem_wdata !== 8'h0) begin
      bad++;
      $display("FAIL reset_mem: got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle_read();
    int acks = 0;
    preload(14'h0123, 8'h5A);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
    tick(); // E0
    total++;
    if (mem_addr !== 14'h0123 || mem_we !== 1'b0 || cpu_ack !== 1'b0) begin
      bad++;
      $display("FAIL idle_grant: got addr=%h we=%b ack=%b want 0123/0/0", mem_addr, mem_we, cpu_ack);
    end
    tick(); // E1
    total++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h5A) begin
      bad++;
      $display("FAIL idle_ack: got ack=%b rdata=%h want 1/5a", cpu_ack, cpu_rdata);
    end
    tick(); // E2, req still sampled high here
    cpu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cpu_ack === 1'b1) acks++;
    end
    total++;
    if (acks !== 0) begin
      bad++;
      $display("FAIL idle_second_ack: got %0d extra acks want 0", acks);
    end
  endtask

  task automatic test_stream_video();
    int nvalid = 0;
    for (int i = 0; i < 8; i++) preload(14'h2000 + 14'(i), 8'(i * 7 + 3));
    for (int t = 0; t < 11; t++) begin
      vid_req  = (t < 8);
      vid_addr = 14'h2000 + 14'(t);
      tick();
      if (t >= 1 && t <= 8) begin
        total++;
        if (vid_valid !== 1'b1 || vid_rdata !== 8'((t - 1) * 7 + 3)) begin
          bad++;
          $display("FAIL stream_%0d: got valid=%b data=%h want 1/%h", t, vid_valid, vid_rdata, 8'((t - 1) * 7 + 3));
        end
      end else if (vid_valid === 1'b1) begin
        nvalid++;
      end
    end
    vid_req = 1'b0;
    total++;
    if (nvalid !== 0) begin
      bad++;
      $display("FAIL stream_extra: got %0d stray valids want 0", nvalid);
    end
  endtask

  task automatic test_tie();
    int cpu_cyc = -1;
    int fill_cyc = -1;
    int ncpu = 0;
    int nfill = 0;
    preload(14'h0020, 8'hFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0010; cpu_wdata = 8'h11;
    fill_req = 1'b1; fill_addr = 14'h0020; fill_wdata = 8'h00;
    tick(); // E0
    total++;
    if (mem_addr !== 14'h0010 || mem_we !== 1'b1 || mem_wdata !== 8'h11) begin
      bad++;
      $display("FAIL tie_first: got addr=%h we=%b wdata=%h want 0010/1/11", mem_addr, mem_we, mem_wdata);
    end
    for (int t = 1; t < 8; t++) begin
      tick();
      if (cpu_ack === 1'b1) begin ncpu++; cpu_cyc = t; cpu_req = 1'b0; end
      if (fill_ack === 1'b1) begin nfill++; fill_cyc = t; fill_req = 1'b0; end
    end
    total++;
    if (ncpu !== 1 || nfill !== 1 || cpu_cyc !== 1 || fill_cyc !== 2) begin
      bad++;
      $display("FAIL tie_acks: got cpu=%0d@%0d fill=%0d@%0d want 1@1 1@2", ncpu, cpu_cyc, nfill, fill_cyc);
    end
    total++;
    if (ram[14'h0010] !== 8'h11 || ram[14'h0020] !== 8'h00) begin
      bad++;
      $display("FAIL tie_ram: got %h %h want 11 00", ram[14'h0010], ram[14'h0020]);
    end
  endtask

  task automatic test_starve();
    int ack_cyc = -1;
    int nack = 0;
    int nstall = 0;
    int stall_cyc = -1;
    vid_req = 1'b1; vid_addr = 14'h2000;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (cpu_ack === 1'b1) begin nack++; ack_cyc = t; cpu_req = 1'b0; end
      if (vid_stall === 1'b1) begin nstall++; stall_cyc = t; end
    end
    vid_req = 1'b0;
`ifdef VRAM_ARB_STARVE_EN
    total++;
    if (nack !== 1 || ack_cyc !== 17) begin
      bad++;
      $display("FAIL starve_ack: got %0d acks last@%0d want 1@17", nack, ack_cyc);
    end
    total++;
    if (nstall !== 1 || stall_cyc !== 17) begin
      bad++;
      $display("FAIL starve_stall: got %0d stalls last@%0d want 1@17", nstall, stall_cyc);
    end
`else
    total++;
    if (nack !== 0 || nstall !== 0) begin
      bad++;
      $display("FAIL strict_video: got acks=%0d stalls=%0d want 0/0", nack, nstall);
    end
    tick(); // CPU granted once video is gone
    tick();
    total++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h5A) begin
      bad++;
      $display("FAIL strict_release: got ack=%b rdata=%h want 1/5a", cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0;
`endif
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_drop_before_grant();
    int nack = 0;
    vid_req = 1'b1; vid_addr = 14'h2001;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0040; cpu_wdata = 8'hEE;
    tick();
    cpu_req = 1'b0;
    vid_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cpu_ack === 1'b1) nack++;
    end
    total++;
    if (nack !== 0) begin
      bad++;
      $display("FAIL drop_no_ack: got %0d acks want 0", nack);
    end
  endtask

  task automatic test_reset_mid_op();
    int nack = 0;
    preload(14'h0030, 8'h00);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0030; cpu_wdata = 8'h77;
    tick(); // E0
    reset = 1'b1;
    #1;
    total++;
    if ({vid_valid, cpu_ack, fill_ack, mem_we, vid_stall} !== 5'b0 || mem_addr !== 14'h0 || mem_wdata !== 8'h0) begin
      bad++;
      $display("FAIL midreset_outputs: got ctl=%b addr=%h wdata=%h want 0", {vid_valid, cpu_ack, fill_ack, mem_we, vid_stall}, mem_addr, mem_wdata);
    end
    tick(); // edge with reset high
    if (cpu_ack === 1'b1) nack++;
    reset = 1'b0;
    tick(); // first edge after release grants the retry
    total++;
    if (mem_addr !== 14'h0030 || mem_we !== 1'b1 || cpu_ack !== 1'b0 || nack !== 0) begin
      bad++;
      $display("FAIL midreset_retry: got addr=%h we=%b ack=%b early=%0d want 0030/1/0/0", mem_addr, mem_we, cpu_ack, nack);
    end
    tick();
    total++;
    if (cpu_ack !== 1'b1) begin
      bad++;
      $display("FAIL midreset_ack: got %b want 1", cpu_ack);
    end
    cpu_req = 1'b0;
    tick();
    total++;
    if (ram[14'h0030] !== 8'h77) begin
      bad++;
      $display("FAIL midreset_ram: got %h want 77", ram[14'h0030]);
    end
  endtask

  initial begin
    test_reset();
    test_idle_read();
    test_stream_video();
    test_tie();
    test_starve();
    test_drop_before_grant();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_arb.md
VRAM_ARB -- requirements
Module: vram_arb

Interface
REQ-001 Parameter ADDR_W, default 14, VRAM address width.
REQ-002 Parameter DATA_W, default 8, VRAM data width.
REQ-003 Parameter STARVE_LIMIT, default 15, number of consecutive video grants with a CPU request waiting before the CPU is forced a slot.
REQ-004 clk  input  1  sole design clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 vid_req  input  1  video fetch request, sampled every edge, fire-and-forget.
REQ-007 vid_addr  input  ADDR_W  video fetch address.
REQ-008 vid_valid  output  1  vid_rdata valid for one cycle.
REQ-009 vid_rdata  output  DATA_W  video read data, a direct copy of mem_rdata.
REQ-010 cpu_req  input  1  CPU access request, held until cpu_ack.
REQ-011 cpu_we  input  1  1 = write, 0 = read.
REQ-012 cpu_addr  input  ADDR_W  CPU address.
REQ-013 cpu_wdata  input  DATA_W  CPU write data.
REQ-014 cpu_ack  output  1  one-cycle completion pulse; cpu_rdata valid when cpu_ack is high on a read.
REQ-015 cpu_rdata  output  DATA_W  CPU read data, a direct copy of mem_rdata.
REQ-016 fill_req  input  1  fill/clear engine write request, held until fill_ack.
REQ-017 fill_addr  input  ADDR_W  fill address.
REQ-018 fill_wdata  input  DATA_W  fill data.
REQ-019 fill_ack  output  1  one-cycle write completion pulse.
REQ-020 mem_addr  output  ADDR_W  registered VRAM address.
REQ-021 mem_wdata  output  DATA_W  registered VRAM write data.
REQ-022 mem_we  output  1  registered VRAM write enable.
REQ-023 mem_rdata  input  DATA_W  VRAM read data; synchronous RAM, valid one cycle after mem_addr.
REQ-024 vid_stall  output  1  high for one cycle when a video request lost its slot.

Function
REQ-025 The arbiter SHALL choose exactly one winner, or none, at each rising edge E0 from the eligible requests.
- The winner's addr/wdata/we are registered onto mem_* at E0.
- mem_we is 0 for video and for CPU reads.
REQ-026 For a read granted at E0, the response SHALL be valid in the cycle between E1 and E2 (vid_valid or cpu_ack high); cpu_ack and fill_ack for writes SHALL be in the same cycle.
REQ-027 Priority SHALL be video first; the CPU and fill requesters share the remaining slots.
REQ-028 CPU/fill arbitration SHALL be round-robin.
- A last_rr flag records which of the two was granted last.
- When both are eligible, the one not granted last wins.
- last_rr updates only on a CPU or fill grant.
REQ-029 A CPU or fill requester SHALL be ineligible from its grant edge E0 through edge E2 inclusive.
- This guarantees one grant per ack even though the requester drops req only at E2.
REQ-030 The video requester SHALL be eligible every edge, allowing back-to-back pipelined reads with one vid_valid per granted vid_req.
REQ-031 When no request is granted, mem_we SHALL be 0; mem_addr and mem_wdata hold their previous values.
REQ-032 The acknowledgment pipeline SHALL track for each slot:
- owner: none, vid, cpu or fill;
- a 2-stage tag shift;
- at most one outstanding CPU op and one outstanding fill op.
REQ-033 If a requester drops req before it is granted, the arbiter SHALL NOT issue an ack and SHALL leave no state behind.
REQ-034 Widths SHALL be as declared.
- No address arithmetic is done in this block.
- The starvation counter is clog2(STARVE_LIMIT+1) bits and saturates, never wraps.

Reset
REQ-035 While reset is high, the block SHALL asynchronously drive:
- vid_valid, cpu_ack, fill_ack, mem_we, vid_stall = 0;
- mem_addr, mem_wdata = 0;
- last_rr = fill (so the CPU wins the first tie);
- starvation counter = 0.
REQ-036 A reset asserted mid-operation SHALL discard all in-flight slots with no ack or valid after release.
REQ-037 After reset release, the first grant SHALL occur at the first rising edge with reset low.

Configuration
REQ-038 Macro VRAM_ARB_STARVE_EN defined: the starvation counter SHALL behave as follows.
- It increments on each video grant while cpu_req is eligible and not granted.
- It clears on any CPU grant or when cpu_req is low.
- When it reaches STARVE_LIMIT, the next edge SHALL grant the CPU over video, and vid_stall is high one cycle later, aligned with where vid_valid would have been.
REQ-039 Macro VRAM_ARB_STARVE_EN undefined: priority SHALL be strictly video first, the counter SHALL be absent, and vid_stall SHALL be tied to 0.

Verification
REQ-040 Idle read: cpu_req=1, cpu_we=0, cpu_addr=0x0123, RAM[0x0123]=0x5A, no video -> mem_addr=0x0123 after E0, cpu_ack=1 with cpu_rdata=0x5A in cycle E1-E2, no second ack.
REQ-041 Streaming video: vid_req held 8 cycles, addresses 0x2000..0x2007 -> 8 consecutive vid_valid pulses carrying RAM[0x2000..0x2007] in order, each 2 edges after its request.
REQ-042 Tie: cpu_req (write 0x11 to 0x0010) and fill_req (write 0x00 to 0x0020) together after reset -> CPU granted first, fill granted next, RAM[0x0010]=0x11, RAM[0x0020]=0x00, one ack each.
REQ-043 Starvation with VRAM_ARB_STARVE_EN and STARVE_LIMIT=15: vid_req held continuously, cpu_req high -> CPU granted at the 16th edge, vid_stall pulses once, counter clears. Without the macro -> no CPU grant while vid_req is high.
REQ-044 Reset mid-op: reset asserted for one cycle between E0 and E1 of a CPU write -> cpu_ack never asserts, all outputs are 0 during reset, and the CPU retry is granted at the first edge after release.
